// File: rtl/maxplus_dot_acc_pkg.sv
// Shared types and constants for the max-plus datapath: state encoding and the epsilon pattern.
// Epsilon (-inf) is the all-ones operand of the chosen width.
package maxplus_pkg;

    localparam int W_DEF = 12;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [63:0] eps_of(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/maxplus_dot_acc_term.sv
// One max-plus term: widened sum of a and b, plus an epsilon flag if either operand is -inf.
// Purely combinational, zero latency, no flow control.
module maxplus_term
    import maxplus_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W:0]   o_sum,
    output logic         o_eps
);

    localparam logic [W-1:0] EPS = W'(eps_of(W));

    // The extra bit holds the carry, so the sum of two finite operands never wraps.
    assign o_sum = {1'b0, i_a} + {1'b0, i_b};
    assign o_eps = (i_a == EPS) || (i_b == EPS);

endmodule

// File: rtl/maxplus_dot_acc.sv
// Max-plus inner product over N operand pairs. The result is valid the cycle after the N-th accept.
// While a result is held, in_ready stays low until the consumer takes the result.
module maxplus_dot_acc
    import maxplus_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_data,
    output logic         out_eps
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [W:0]    r_acc;
    logic          r_any_fin;

    logic [W:0]    w_term;
    logic          w_term_eps;
    logic          w_in_xfer;

    maxplus_term #(.W(W)) u_term (
        .i_a   (a_in),
        .i_b   (b_in),
        .o_sum (w_term),
        .o_eps (w_term_eps)
    );

    assign w_in_xfer = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_eps     = 1'b0;
        case (r_state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && (r_cnt == LAST)) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                out_data  = r_any_fin ? r_acc : '0;
                out_eps   = !r_any_fin;
                if (out_ready) begin
                    w_state_nxt = ACC;
                end
            end
            default: w_state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ACC;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_any_fin <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_xfer) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
                if (r_cnt == '0) begin
                    r_acc     <= w_term_eps ? '0 : w_term;
                    r_any_fin <= !w_term_eps;
                end else if (!w_term_eps) begin
                    // Until a finite term arrives, acc holds no meaningful value to compare against.
                    r_acc     <= (r_any_fin && (r_acc > w_term)) ? r_acc : w_term;
                    r_any_fin <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxplus_dot_acc.sv
// Scoreboarded bench for maxplus_dot_acc: directed vectors plus randomized traffic against a plain max-of-sums model.
module tb_maxplus_dot_acc;

    localparam int W   = 12;
    localparam int N   = 4;
    localparam int EPS = 4095;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W:0]    out_data;
    logic          out_eps;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [W+1:0]  exp_q[$];
    logic          rand_rdy = 1'b0;

    maxplus_dot_acc #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_eps   (out_eps)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the largest sum among pairs where neither operand is epsilon.
    function automatic logic [W+1:0] ref_result(input int a[N], input int b[N]);
        int best = -1;
        for (int k = 0; k < N; k++) begin
            if (a[k] != EPS && b[k] != EPS && a[k] + b[k] > best) best = a[k] + b[k];
        end
        if (best < 0) return {1'b1, {(W+1){1'b0}}};
        return {1'b0, 13'(best)};
    endfunction

    // Monitor: pops on every output transfer and checks held outputs do not change under backpressure.
    initial begin
        logic         held = 1'b0;
        logic [W+1:0] prev = '0;
        logic [W+1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                check("in_ready_while_holding", in_ready, 0);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("out_eps", out_eps, exp[W+1]);
                        check("out_data", out_data, exp[W:0]);
                    end
                    held = 1'b0;
                end else begin
                    if (held) check("held_stable", {out_eps, out_data}, prev);
                    prev = {out_eps, out_data};
                    held = 1'b1;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic push_pair(input int a, input int b, output logic took);
        int guard = 0;
        took = 1'b0;
        a_in = 12'(a);
        b_in = 12'(b);
        in_valid = 1'b1;
        while (!took && guard < 1000) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!took) check("accept_timeout", 0, 1);
    endtask

    // gap: 0 = back-to-back, 1 = one idle cycle after every pair, 2 = random idle cycles.
    task automatic send_vec(input int a[N], input int b[N], input int gap);
        logic took;
        exp_q.push_back(ref_result(a, b));
        for (int k = 0; k < N; k++) begin
            push_pair(a[k], b[k], took);
            if (!took) return;
            if (k < N - 1) check("no_early_valid", out_valid, 0);
            else           check("latency_out_valid", out_valid, 1);
            if (k < N - 1) begin
                if (gap == 1) begin
                    @(posedge clk); #1;
                end else if (gap == 2) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
        end
    endtask

    initial begin
        int   a[N];
        int   b[N];
        logic took;
        int   guard;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_eps", out_eps, 0);
        @(posedge clk); #1;

        // Basic result, in_ready low for exactly one cycle.
        a = '{1, 2, 3, 4};    b = '{10, 20, 5, 1};
        send_vec(a, b, 0);
        check("in_ready_low_after_last", in_ready, 0);
        @(posedge clk); #1;
        check("in_ready_back_high", in_ready, 1);

        // Width rule.
        a = '{4094, 0, 0, 0}; b = '{4094, 0, 0, 0};
        send_vec(a, b, 0);

        // All-epsilon vector, then mixed epsilons.
        a = '{EPS, EPS, EPS, EPS}; b = '{5, 0, 4094, EPS};
        send_vec(a, b, 0);
        a = '{EPS, 7, EPS, 2};  b = '{0, 3, 100, 1};
        send_vec(a, b, 0);

        // Backpressure: five stalled cycles, then release and send another vector.
        @(posedge clk); #1;
        out_ready = 1'b0;
        a = '{9, 8, 7, 6};    b = '{1, 1, 1, 1};
        send_vec(a, b, 0);
        repeat (5) @(posedge clk);
        #1;
        check("held_valid", out_valid, 1);
        check("held_in_ready", in_ready, 0);
        out_ready = 1'b1;
        a = '{0, 0, 0, 9};    b = '{0, 0, 0, 1};
        send_vec(a, b, 0);

        // Reset mid-vector discards the partial sum.
        @(posedge clk); #1;
        push_pair(200, 300, took);
        push_pair(250, 250, took);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        a = '{1, 1, 1, 1};    b = '{1, 1, 1, 1};
        send_vec(a, b, 0);

        // Bubbles on in_valid.
        @(posedge clk); #1;
        a = '{1, 2, 3, 4};    b = '{10, 20, 5, 1};
        send_vec(a, b, 1);

        // Randomized traffic with random output backpressure.
        rand_rdy = 1'b1;
        for (int v = 0; v < 40; v++) begin
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 3))
                    0:       a[k] = EPS;
                    1:       a[k] = $urandom_range(0, 7);
                    default: a[k] = $urandom_range(0, 4094);
                endcase
                case ($urandom_range(0, 3))
                    0:       b[k] = EPS;
                    1:       b[k] = $urandom_range(0, 7);
                    default: b[k] = $urandom_range(0, 4094);
                endcase
            end
            send_vec(a, b, 2);
        end

        rand_rdy = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        @(negedge clk);
        check("idle_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
